// File: rtl/v74x148_pkg.sv
// Shared definitions for the registered 74x148-style priority encoder:
// default input count, controller states and the encoded-width helper.
package v74x148_pkg;

  // Default number of active-low request lines.
  localparam int N_IN_DEF = 8;

  // Controller states: nothing held, or a code held until ACK.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Encoded index width for a given request count (never narrower than 1).
  function automatic int aw_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/v74x148_sync_encoder_prio_search.sv
// Combinational priority search over an active-high request vector.
// The search begins at index 'start' and descends with wrap-around
// (start, start-1, ..., 0, N_IN-1, ...). The first request hit is reported.
// With start tied to N_IN-1 this is plain 74x148 fixed priority.
module prio_search #(
  parameter int N_IN = 8,
  parameter int AW   = 3
) (
  input  logic [N_IN-1:0] req,
  input  logic [AW-1:0]   start,
  output logic            found,
  output logic [AW-1:0]   idx
);

  logic [AW-1:0] cand;

  // Walk from the lowest search priority up to the highest so the
  // highest-priority hit overwrites the others; wrap comes from AW-bit math.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      cand = start - AW'(i);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/v74x148_sync_encoder.sv
// Registered 8-to-3 (generally N_IN-to-AW) priority encoder with a
// VALID/ACK hold. A captured index is presented active-low on A_L and held
// until ACK; the outputs mirror the 74x148 (GS_L, EO_L) so A_L can drive
// the existing 74x139-style decoder path after inversion.
// Optional build macro: V74X148_ROUND_ROBIN_EN adds a rotating search
// pointer so repeated requests are granted in turn instead of by fixed order.
module v74x148_sync_encoder
  import v74x148_pkg::*;
#(
  parameter  int N_IN = N_IN_DEF,
  localparam int AW   = aw_of(N_IN)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            EI_L,
  input  logic [N_IN-1:0] I_L,
  input  logic            ACK,
  output logic [AW-1:0]   A_L,
  output logic            GS_L,
  output logic            EO_L,
  output logic            VALID
);

  state_t        state;
  logic [AW-1:0] start_idx;
  logic          found;
  logic [AW-1:0] hit_idx;
  logic          capture;

  // Requests are active-low on the pins; the search works active-high.
  prio_search #(
    .N_IN (N_IN),
    .AW   (AW)
  ) u_search (
    .req   (~I_L),
    .start (start_idx),
    .found (found),
    .idx   (hit_idx)
  );

  // A capture happens only from IDLE while enabled with at least one request.
  assign capture = (state == IDLE) && !EI_L && found;

`ifdef V74X148_ROUND_ROBIN_EN
  logic [AW-1:0] ptr;

  // Rotate the search start to just below the last granted index.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ptr <= AW'(N_IN - 1);
    end else if (capture) begin
      ptr <= hit_idx - AW'(1);
    end
  end

  assign start_idx = ptr;
`else
  assign start_idx = AW'(N_IN - 1);
`endif

  // Capture/hold/release controller and registered encoder outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      A_L   <= '1;
      GS_L  <= 1'b1;
      EO_L  <= 1'b1;
    end else begin
      EO_L <= ~(!EI_L && (&I_L));
      case (state)
        IDLE: begin
          if (capture) begin
            A_L   <= ~hit_idx;
            GS_L  <= 1'b0;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (ACK) begin
            A_L   <= '1;
            GS_L  <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          A_L   <= '1;
          GS_L  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  // VALID is simply the active-high view of the registered group select.
  assign VALID = ~GS_L;

endmodule

// File: tb/tb_v74x148_sync_encoder.sv
// Directed self-checking bench for v74x148_sync_encoder (N_IN = 8).
// Honours V74X148_ROUND_ROBIN_EN for the grant-order sequence.
module tb_v74x148_sync_encoder;

  logic       CLK;
  logic       RESET;
  logic       EI_L;
  logic [7:0] I_L;
  logic       ACK;
  logic [2:0] A_L;
  logic       GS_L;
  logic       EO_L;
  logic       VALID;

  int testsRun    = 0;
  int testsFailed = 0;

  v74x148_sync_encoder #(.N_IN(8)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .EI_L  (EI_L),
    .I_L   (I_L),
    .ACK   (ACK),
    .A_L   (A_L),
    .GS_L  (GS_L),
    .EO_L  (EO_L),
    .VALID (VALID)
  );

  // 10-time-unit clock, rising edges at 5, 15, 25, ...
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single comparison with assertion-based failure reporting.
  task automatic checkOne(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    testsRun++;
    assert (obs === exp)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare all four outputs against hand-computed values.
  task automatic checkOutput(input string tag, input logic [2:0] expA,
                             input logic expGs, input logic expValid, input logic expEo);
    checkOne({tag, ".A_L"},   {5'd0, A_L},   {5'd0, expA});
    checkOne({tag, ".GS_L"},  {7'd0, GS_L},  {7'd0, expGs});
    checkOne({tag, ".VALID"}, {7'd0, VALID}, {7'd0, expValid});
    checkOne({tag, ".EO_L"},  {7'd0, EO_L},  {7'd0, expEo});
  endtask

  // Drive inputs, then advance one rising edge and settle 1 unit past it.
  task automatic applyStimulus(input logic ei, input logic [7:0] il, input logic ack);
    EI_L = ei;
    I_L  = il;
    ACK  = ack;
    @(posedge CLK);
    #1;
  endtask

  logic [2:0] expGrant [4];

  initial begin
    RESET = 1'b1;
    EI_L  = 1'b1;
    I_L   = 8'h00;
    ACK   = 1'b0;
    #2;
    checkOutput("in_reset", 3'b111, 1'b1, 1'b0, 1'b1);
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    // Disabled: requests present but EI_L high, nothing captured.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'h00, 1'b0);
      checkOutput($sformatf("disabled_%0d", i), 3'b111, 1'b1, 1'b0, 1'b1);
    end

    // ACK while IDLE has no effect.
    applyStimulus(1'b1, 8'hFF, 1'b1);
    checkOutput("ack_idle", 3'b111, 1'b1, 1'b0, 1'b1);

    // Bits 5 and 3 low: index 5 wins, A_L = ~5.
    applyStimulus(1'b0, 8'b1101_0111, 1'b0);
    checkOutput("capture5", 3'b010, 1'b0, 1'b1, 1'b1);

    // HOLD ignores new requests.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'hFE, 1'b0);
      checkOutput($sformatf("hold5_%0d", i), 3'b010, 1'b0, 1'b1, 1'b1);
    end

    // ACK releases; no capture on the ACK edge.
    applyStimulus(1'b0, 8'hFE, 1'b1);
    checkOutput("release5", 3'b111, 1'b1, 1'b0, 1'b1);

    // Next edge captures index 0, A_L = ~0.
    applyStimulus(1'b0, 8'hFE, 1'b0);
    checkOutput("capture0", 3'b111, 1'b0, 1'b1, 1'b1);

    // Release with no requests: EO_L goes low on this edge.
    applyStimulus(1'b0, 8'hFF, 1'b1);
    checkOutput("release0", 3'b111, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'hFF, 1'b0);
    checkOutput("enabled_no_req", 3'b111, 1'b1, 1'b0, 1'b0);

    // Index 7 request: EO_L back high, A_L = 000.
    applyStimulus(1'b0, 8'h7F, 1'b0);
    checkOutput("capture7", 3'b000, 1'b0, 1'b1, 1'b1);

    // Release and capture index 6, A_L = 001.
    applyStimulus(1'b0, 8'hBF, 1'b1);
    checkOutput("release7", 3'b111, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'hBF, 1'b0);
    checkOutput("capture6", 3'b001, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset mid-cycle discards the held code before any edge.
    #4;
    RESET = 1'b1;
    #1;
    checkOutput("async_reset", 3'b111, 1'b1, 1'b0, 1'b1);
    #2;
    RESET = 1'b0;

    // First edge after reset release captures again.
    applyStimulus(1'b0, 8'hBF, 1'b0);
    checkOutput("recapture6", 3'b001, 1'b0, 1'b1, 1'b1);

    // Fresh reset so the grant-order check starts from the reset pointer.
    #4;
    RESET = 1'b1;
    #1;
    checkOutput("reset2", 3'b111, 1'b1, 1'b0, 1'b1);
    #2;
    RESET = 1'b0;

`ifdef V74X148_ROUND_ROBIN_EN
    expGrant[0] = 3'd7;
    expGrant[1] = 3'd5;
    expGrant[2] = 3'd7;
    expGrant[3] = 3'd5;
`else
    expGrant[0] = 3'd7;
    expGrant[1] = 3'd7;
    expGrant[2] = 3'd7;
    expGrant[3] = 3'd7;
`endif

    // Bits 7 and 5 held low, ACK every HOLD.
    for (int g = 0; g < 4; g++) begin
      applyStimulus(1'b0, 8'h5F, 1'b0);
      checkOutput($sformatf("grant_%0d", g), ~expGrant[g], 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 8'h5F, 1'b1);
      checkOutput($sformatf("grant_rel_%0d", g), 3'b111, 1'b1, 1'b0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
